// File: rtl/id_ex_forward_stage.sv
// rtl/id_ex_forward_stage.sv - ID/EX pipeline register with hazard detection and operand forwarding.
// Optional macro FORWARD_EN: forward from EX/MEM and MEM/WB; otherwise stall on RAW hazards.
module id_ex_forward_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [WIDTH-1:0] id_rsdata,
  input  logic [WIDTH-1:0] id_rtdata,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [3:0]       id_aluop,
  input  logic             id_alusrc,
  input  logic             id_regdst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             flush,
  input  logic             exmem_regwrite,
  input  logic [4:0]       exmem_rd,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic             memwb_regwrite,
  input  logic [4:0]       memwb_rd,
  input  logic [WIDTH-1:0] memwb_result,
  output logic             stall,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic             ex_valid,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic [4:0]       ex_dest,
  output logic [WIDTH-1:0] ex_storedata
);

  localparam logic [3:0] ALU_ADD = 4'd2;

  logic             valid_q, valid_d;
  logic [4:0]       rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [WIDTH-1:0] rsdata_q, rsdata_d, rtdata_q, rtdata_d, imm_q, imm_d;
  logic [3:0]       aluop_q, aluop_d;
  logic             alusrc_q, alusrc_d, regdst_q, regdst_d;
  logic             regwrite_q, regwrite_d, memread_q, memread_d, memwrite_q, memwrite_d;

  logic             hz_lu, hz_raw;
  logic [WIDTH-1:0] fwd_a, fwd_b;

  assign ex_dest = regdst_q ? rd_q : rt_q;

  assign hz_lu = valid_q && memread_q && (ex_dest != 5'd0) &&
                 ((ex_dest == id_rs) || (ex_dest == id_rt)) && id_valid;

`ifdef FORWARD_EN
  always_comb begin
    hz_raw = 1'b0;
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs_q))
      fwd_a = exmem_result;
    else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs_q))
      fwd_a = memwb_result;
    else
      fwd_a = rsdata_q;
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rt_q))
      fwd_b = exmem_result;
    else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rt_q))
      fwd_b = memwb_result;
    else
      fwd_b = rtdata_q;
  end
`else
  logic ex_wr, mem_wr, rs_hit, rt_hit;
  logic unused_memwb;

  // WB producers need no stall: the register file writes before it is read.
  assign unused_memwb = ^{memwb_regwrite, memwb_rd, memwb_result};

  always_comb begin
    fwd_a  = rsdata_q;
    fwd_b  = rtdata_q;
    ex_wr  = valid_q && regwrite_q;
    mem_wr = exmem_regwrite;
    rs_hit = (id_rs != 5'd0) &&
             ((ex_wr && (ex_dest == id_rs)) || (mem_wr && (exmem_rd == id_rs)));
    rt_hit = (id_rt != 5'd0) &&
             ((ex_wr && (ex_dest == id_rt)) || (mem_wr && (exmem_rd == id_rt)));
    hz_raw = id_valid && (rs_hit || rt_hit);
  end
`endif

  assign stall = (hz_lu || hz_raw) && !flush;

  // Bubbles zero rs/rt so a stale register number can never pick up a forward.
  always_comb begin
    valid_d    = id_valid;
    rs_d       = id_rs;
    rt_d       = id_rt;
    rd_d       = id_rd;
    rsdata_d   = id_rsdata;
    rtdata_d   = id_rtdata;
    imm_d      = id_imm;
    aluop_d    = id_aluop;
    alusrc_d   = id_alusrc;
    regdst_d   = id_regdst;
    regwrite_d = id_regwrite;
    memread_d  = id_memread;
    memwrite_d = id_memwrite;
    if (stall || flush) begin
      valid_d    = 1'b0;
      rs_d       = 5'd0;
      rt_d       = 5'd0;
      rd_d       = 5'd0;
      rsdata_d   = '0;
      rtdata_d   = '0;
      imm_d      = '0;
      aluop_d    = ALU_ADD;
      alusrc_d   = 1'b0;
      regdst_d   = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      rs_q       <= 5'd0;
      rt_q       <= 5'd0;
      rd_q       <= 5'd0;
      rsdata_q   <= '0;
      rtdata_q   <= '0;
      imm_q      <= '0;
      aluop_q    <= ALU_ADD;
      alusrc_q   <= 1'b0;
      regdst_q   <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      rsdata_q   <= rsdata_d;
      rtdata_q   <= rtdata_d;
      imm_q      <= imm_d;
      aluop_q    <= aluop_d;
      alusrc_q   <= alusrc_d;
      regdst_q   <= regdst_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
    end
  end

  assign alu_a        = fwd_a;
  assign alu_b        = alusrc_q ? imm_q : fwd_b;
  assign alu_op       = aluop_q;
  assign ex_valid     = valid_q;
  assign ex_regwrite  = regwrite_q;
  assign ex_memread   = memread_q;
  assign ex_memwrite  = memwrite_q;
  assign ex_storedata = fwd_b;

endmodule

// File: tb/tb_id_ex_forward_stage.sv
// tb/tb_id_ex_forward_stage.sv - Self-checking bench for id_ex_forward_stage (both FORWARD_EN builds).
module tb_id_ex_forward_stage;

  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsdata, rtdata, imm;
    logic [3:0]  aluop;
    logic        alusrc, regdst, regwrite, memread, memwrite;
  } instr_t;

  typedef struct {
    instr_t      ins;
    logic        flush;
    logic        xm_we;
    logic [4:0]  xm_rd;
    logic [31:0] xm_res;
    logic        ev, erw, emr, emw;
    logic [4:0]  edest;
    logic [3:0]  eop;
    logic [31:0] ea, eb, esd;
  } vec_t;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rsdata, id_rtdata, id_imm;
  logic [3:0]  id_aluop;
  logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite;
  logic        flush;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        stall;
  logic [31:0] alu_a, alu_b, ex_storedata;
  logic [3:0]  alu_op;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [4:0]  ex_dest;

  int checks = 0;
  int errors = 0;

  vec_t vecs[7];

  id_ex_forward_stage #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rsdata(id_rsdata), .id_rtdata(id_rtdata), .id_imm(id_imm),
    .id_aluop(id_aluop), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall(stall), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_dest(ex_dest), .ex_storedata(ex_storedata)
  );

  always #5 clock = ~clock;

  function automatic instr_t mk(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic [31:0] rsd, logic [31:0] rtd, logic [31:0] imm,
                                logic [3:0] op, logic src, logic dst, logic rw,
                                logic mr, logic mw);
    instr_t i;
    i.valid = 1'b1; i.rs = rs; i.rt = rt; i.rd = rd;
    i.rsdata = rsd; i.rtdata = rtd; i.imm = imm; i.aluop = op;
    i.alusrc = src; i.regdst = dst; i.regwrite = rw; i.memread = mr; i.memwrite = mw;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    id_valid = i.valid; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
    id_rsdata = i.rsdata; id_rtdata = i.rtdata; id_imm = i.imm; id_aluop = i.aluop;
    id_alusrc = i.alusrc; id_regdst = i.regdst; id_regwrite = i.regwrite;
    id_memread = i.memread; id_memwrite = i.memwrite;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mkv(instr_t i, logic fl, logic xw, logic [4:0] xr, logic [31:0] xres,
                               logic ev, logic erw, logic emr, logic emw, logic [4:0] ed,
                               logic [3:0] eop, logic [31:0] ea, logic [31:0] eb,
                               logic [31:0] esd);
    vec_t v;
    v.ins = i; v.flush = fl; v.xm_we = xw; v.xm_rd = xr; v.xm_res = xres;
    v.ev = ev; v.erw = erw; v.emr = emr; v.emw = emw; v.edest = ed;
    v.eop = eop; v.ea = ea; v.eb = eb; v.esd = esd;
    return v;
  endfunction

  initial begin
    // ADD, ADDI, SW, flushed SLT, AND, LW, SUB with rs=0 against exmem_rd=0
    vecs[0] = mkv(mk(1, 2, 3, 32'h5, 32'h7, 32'd100, 4'd2, 0, 1, 1, 0, 0), 0, 0, 0, 0,
                  1, 1, 0, 0, 5'd3, 4'd2, 32'h5, 32'h7, 32'h7);
    vecs[1] = mkv(mk(4, 6, 9, 32'h11, 32'h22, 32'hFFFF_FFF0, 4'd2, 1, 0, 1, 0, 0), 0, 0, 0, 0,
                  1, 1, 0, 0, 5'd6, 4'd2, 32'h11, 32'hFFFF_FFF0, 32'h22);
    vecs[2] = mkv(mk(7, 8, 0, 32'h1000, 32'hDEAD, 32'd4, 4'd2, 1, 0, 0, 0, 1), 0, 0, 0, 0,
                  1, 0, 0, 1, 5'd8, 4'd2, 32'h1000, 32'd4, 32'hDEAD);
    vecs[3] = mkv(mk(10, 11, 12, 32'h9, 32'h8, 32'h3, 4'd7, 0, 1, 1, 0, 0), 1, 0, 0, 0,
                  0, 0, 0, 0, 5'd0, 4'd2, 32'h0, 32'h0, 32'h0);
    vecs[4] = mkv(mk(12, 13, 14, 32'hF0F0, 32'h0FF0, 32'h0, 4'd0, 0, 1, 1, 0, 0), 0, 0, 0, 0,
                  1, 1, 0, 0, 5'd14, 4'd0, 32'hF0F0, 32'h0FF0, 32'h0FF0);
    vecs[5] = mkv(mk(16, 17, 0, 32'h2000, 32'h33, 32'd8, 4'd2, 1, 0, 1, 1, 0), 0, 0, 0, 0,
                  1, 1, 1, 0, 5'd17, 4'd2, 32'h2000, 32'd8, 32'h33);
    vecs[6] = mkv(mk(0, 18, 19, 32'h77, 32'h88, 32'h0, 4'd6, 0, 1, 1, 0, 0), 0, 1, 0, 32'hFFFF,
                  1, 1, 0, 0, 5'd19, 4'd6, 32'h77, 32'h88, 32'h88);

    reset = 1'b1; flush = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0));
    id_valid = 1'b0;
    exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'h0;
    memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_result = 32'h0;

    #2;
    chk("reset_state", {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_dest, alu_op,
                        alu_a, alu_b, ex_storedata, stall},
        {1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'd2, 32'h0, 32'h0, 32'h0, 1'b0});
    #10;
    reset = 1'b0;

    for (int k = 0; k < 7; k++) begin
      drive(vecs[k].ins);
      flush = vecs[k].flush;
      exmem_regwrite = vecs[k].xm_we; exmem_rd = vecs[k].xm_rd; exmem_result = vecs[k].xm_res;
      tick();
      id_valid = 1'b0; flush = 1'b0;
      @(negedge clock);
      chk($sformatf("vector_%0d", k),
          {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_dest, alu_op,
           alu_a, alu_b, ex_storedata, stall},
          {vecs[k].ev, vecs[k].erw, vecs[k].emr, vecs[k].emw, vecs[k].edest, vecs[k].eop,
           vecs[k].ea, vecs[k].eb, vecs[k].esd, 1'b0});
    end
    exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'h0;

    // load-use: one stall cycle, bubble, then capture
    drive(mk(1, 5, 0, 32'h3000, 32'h0, 32'h0, 4'd2, 1, 0, 0, 1, 0));
    tick();
    drive(mk(5, 2, 6, 32'h1, 32'h2, 32'h0, 4'd2, 0, 1, 1, 0, 0));
    @(negedge clock);
    chk("lu_stall", {31'h0, stall}, {31'h0, 1'b1});
    tick();
    @(negedge clock);
    chk("lu_bubble", {ex_valid, stall, ex_memread, alu_op}, {1'b0, 1'b0, 1'b0, 4'd2});
    tick();
    id_valid = 1'b0;
    @(negedge clock);
    chk("lu_capture", {ex_valid, ex_dest, alu_a, alu_b}, {1'b1, 5'd6, 32'h1, 32'h2});

    // load-use coinciding with flush: flush wins
    drive(mk(1, 5, 0, 32'h3000, 32'h0, 32'h0, 4'd2, 1, 0, 0, 1, 0));
    tick();
    drive(mk(5, 2, 6, 32'h1, 32'h2, 32'h0, 4'd2, 0, 1, 1, 0, 0));
    flush = 1'b1;
    @(negedge clock);
    chk("flush_no_stall", {31'h0, stall}, {31'h0, 1'b0});
    tick();
    flush = 1'b0; id_valid = 1'b0;
    @(negedge clock);
    chk("flush_bubble", {ex_valid, ex_regwrite, ex_memread, alu_op},
        {1'b0, 1'b0, 1'b0, 4'd2});

    // forwarding priority: EX/MEM over MEM/WB
    drive(mk(3, 3, 7, 32'h99, 32'hAA, 32'h0, 4'd6, 0, 1, 1, 0, 0));
    tick();
    id_valid = 1'b0;
    exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h10;
    memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h20;
    @(negedge clock);
    chk("fwd_exmem_wins", {alu_a, ex_storedata},
        FWD ? {32'h10, 32'h10} : {32'h99, 32'hAA});
    exmem_regwrite = 1'b0;
    #1;
    chk("fwd_memwb", {alu_a, alu_b}, FWD ? {32'h20, 32'h20} : {32'h99, 32'hAA});
    memwb_regwrite = 1'b0;

    // RAW on rt against a plain ALU producer
    drive(mk(1, 2, 4, 32'h0, 32'h0, 32'h0, 4'd2, 0, 1, 1, 0, 0));
    tick();
    drive(mk(8, 4, 9, 32'h40, 32'h41, 32'h0, 4'd2, 0, 1, 1, 0, 0));
    @(negedge clock);
    chk("raw_stall_ex", {31'h0, stall}, {31'h0, !FWD});
    tick();
    exmem_regwrite = 1'b1; exmem_rd = 5'd4; exmem_result = 32'h123;
    @(negedge clock);
    chk("raw_stall_mem", {stall, ex_valid}, {!FWD, FWD});
    tick();
    exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'h0;
    @(negedge clock);
    chk("raw_release", {31'h0, stall}, {31'h0, 1'b0});
    tick();
    id_valid = 1'b0;
    @(negedge clock);
    chk("raw_capture", {ex_valid, ex_dest, alu_b}, {1'b1, 5'd9, 32'h41});

    // asynchronous reset while a load-use stall is pending
    drive(mk(1, 5, 0, 32'h3000, 32'h0, 32'h0, 4'd2, 1, 0, 0, 1, 0));
    tick();
    drive(mk(5, 2, 6, 32'h1, 32'h2, 32'h0, 4'd2, 0, 1, 1, 0, 0));
    @(negedge clock);
    chk("pre_reset_stall", {ex_valid, stall}, {1'b1, 1'b1});
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", {ex_valid, alu_op, stall, ex_memread, alu_a},
        {1'b0, 4'd2, 1'b0, 1'b0, 32'h0});
    #1;
    reset = 1'b0;
    tick();
    id_valid = 1'b0;
    @(negedge clock);
    chk("post_reset_capture", {ex_valid, ex_dest, alu_a}, {1'b1, 5'd6, 32'h1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_forward_stage.md
ID_EX_FORWARD_STAGE -- requirements
Module: id_ex_forward_stage

Interface
REQ-001 Parameter: WIDTH, 32, data path width of operands, immediate and results.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 id_valid  in  1  decode slot holds a real instruction.
REQ-005 id_rs, id_rt, id_rd  in  5 each  source and destination register numbers from decode.
REQ-006 id_rsdata, id_rtdata, id_imm  in  WIDTH each  register file read data and sign-extended immediate.
REQ-007 id_aluop  in  4  ALU operation code (0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT).
REQ-008 id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite  in  1 each  decode controls.
REQ-009 flush  in  1  taken branch; kill the decode-slot instruction.
REQ-010 exmem_regwrite  in  1; exmem_rd  in  5; exmem_result  in  WIDTH; these describe the MEM-stage producer.
REQ-011 memwb_regwrite  in  1; memwb_rd  in  5; memwb_result  in  WIDTH; these describe the WB-stage producer.
REQ-012 stall  out  1  hold PC and IF/ID this cycle (combinational).
REQ-013 alu_a, alu_b  out  WIDTH each; alu_op  out  4; these are the operands and opcode driven to the ALU.
REQ-014 ex_valid, ex_regwrite, ex_memread, ex_memwrite  out  1 each; ex_dest  out  5; ex_storedata  out  WIDTH.

Function
REQ-015 On each rising edge with stall=0 and flush=0, all id_* fields SHALL be captured into the EX register, and ex_valid SHALL take id_valid.
REQ-016 On an edge with stall=1 or flush=1, a bubble SHALL be loaded: ex_valid=0, ex_regwrite=0, ex_memread=0, ex_memwrite=0, and alu_op=2.
REQ-017 ex_dest SHALL be the registered rd when regdst=1, otherwise the registered rt.
REQ-018 Load-use hazard (hz_lu): ex_valid & ex_memread & ex_dest!=0 & (ex_dest==id_rs | ex_dest==id_rt) & id_valid.
REQ-019 stall SHALL be asserted when (hz_lu | hz_raw) & !flush, where hz_raw is 0 when FORWARD_EN is defined; flush SHALL take priority over stall.
REQ-020 Forward A (FORWARD_EN defined) SHALL select, in priority order: exmem_result when exmem_regwrite & exmem_rd!=0 & exmem_rd==ex_rs; else memwb_result when memwb_regwrite & memwb_rd!=0 & memwb_rd==ex_rs; else the registered rsdata.
REQ-021 Forward B SHALL use the same selection against ex_rt, and its result SHALL drive ex_storedata.
REQ-022 alu_a SHALL be forward A; alu_b SHALL be the registered imm when alusrc=1, otherwise forward B.
REQ-023 Register 0 SHALL never be forwarded or cause a hazard.
REQ-024 Operand outputs SHALL be valid in the same cycle the instruction occupies EX; capture latency SHALL be one clock.
REQ-025 Outputs SHALL be don't-care-free: a bubble drives alu_a=0, alu_b=0, and ex_storedata=0.

Reset
REQ-026 While reset=1, the EX register SHALL hold a bubble per REQ-016 with all data fields 0, independent of clock.
REQ-027 Reset asserted mid-stall SHALL clear the bubble state, and stall SHALL then follow only the current id_* inputs.
REQ-028 The first edge after reset deassertion SHALL capture normally.

Configuration
REQ-029 When macro FORWARD_EN is defined, REQ-020/REQ-021 forwarding SHALL be present, and hz_raw SHALL be 0.
REQ-030 When FORWARD_EN is undefined, forward A/B SHALL equal the registered rsdata/rtdata, and hz_raw SHALL be asserted when id_valid and a nonzero id_rs or id_rt matches either (ex_dest with ex_valid & ex_regwrite) or (exmem_rd with exmem_regwrite); the WB stage is covered by write-first register file.

Verification
REQ-031 With FORWARD_EN, ADD r3 in EX, then next instruction SUB uses r3: exmem_rd=3, exmem_result=0x10, memwb_rd=3, memwb_result=0x20 -> alu_a=0x10 (EX/MEM wins).
REQ-032 LW r5 in EX, decode uses rs=5 -> stall=1 for exactly one cycle, next EX shows ex_valid=0, and the following edge captures the instruction.
REQ-033 Load-use hazard with flush=1 in the same cycle -> stall=0 and a bubble is loaded.
REQ-034 Instruction with rs=0 and exmem_rd=0, exmem_regwrite=1, exmem_result=0xFFFF -> alu_a equals the registered rsdata (no forward).
REQ-035 Without FORWARD_EN, ADD r4 in EX and decode reads rt=4 -> stall=1 for two cycles (EX, then MEM), then capture.
REQ-036 Assert reset asynchronously between edges with ex_valid=1 -> ex_valid=0 and alu_op=2 immediately.
